// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, EX redirects,
// dmem wait freezes, dmem timeout halt and a stall-cycle counter.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_rd,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_wr,
  output logic             if_id_wr,
  output logic             if_id_flush,
  output logic             id_ex_wr,
  output logic             id_ex_flush,
  output logic             ex_mem_wr,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [TO_W-1:0]  r_wait;
  logic [TO_W-1:0]  w_wait_nxt;
  logic [CNT_W-1:0] r_stall;
  logic             w_busy;
  logic             w_hit1;
  logic             w_hit2;
  logic             w_load_use;

  assign w_busy     = dmem_req & ~dmem_ack;
  assign w_hit1     = id_use_rs1 && (id_rs1 == ex_rd);
  assign w_hit2     = id_use_rs2 && (id_rs2 == ex_rd);
  assign w_load_use = ex_mem_rd && (ex_rd != 5'd0)
                      && (w_hit1 || w_hit2);

  // Pipeline register controls, highest priority first
  always_comb begin
    pc_wr        = 1'b1;
    if_id_wr     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_wr     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_wr    = 1'b1;
    mem_wb_flush = 1'b0;
    halted       = 1'b0;
    if (rst) begin
      pc_wr        = 1'b0;
      if_id_wr     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_wr     = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_wr    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (r_state == S_HALT) begin
      pc_wr     = 1'b0;
      if_id_wr  = 1'b0;
      id_ex_wr  = 1'b0;
      ex_mem_wr = 1'b0;
      halted    = 1'b1;
    end else if (w_busy) begin
      pc_wr        = 1'b0;
      if_id_wr     = 1'b0;
      id_ex_wr     = 1'b0;
      ex_mem_wr    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_wr       = 1'b0;
      if_id_wr    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_wait_nxt = r_wait;
    unique case (r_state)
      S_RUN: begin
        if (w_busy) begin
          w_next     = S_WAIT;
          w_wait_nxt = TO_W'(1);
        end
      end
      S_WAIT: begin
        if (!w_busy) begin
          w_next     = S_RUN;
          w_wait_nxt = '0;
        end else if (r_wait == TO_W'(MEM_TIMEOUT)) begin
          w_next = S_HALT;
        end else begin
          w_wait_nxt = r_wait + TO_W'(1);
        end
      end
      default: begin
        w_next = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
    end
  end

  // Saturating count of cycles where the PC did not advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (!pc_wr && (r_stall != '1)) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign stall_count = r_stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl.
// Output vector: {pc,ifw,iff,idw,idf,exw,mwf}.
module tb_hazard_ctrl;

  localparam logic [6:0] V_RUN = 7'b1101010;
  localparam logic [6:0] V_FRZ = 7'b0000001;
  localparam logic [6:0] V_RED = 7'b1111110;
  localparam logic [6:0] V_LU  = 7'b0001110;
  localparam logic [6:0] V_HLT = 7'b0000000;
  localparam logic [6:0] V_RST = 7'b0010101;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_mem_rd, ex_redirect;
  logic        dmem_req, dmem_ack;
  logic        pc_wr, if_id_wr, if_id_flush;
  logic        id_ex_wr, id_ex_flush;
  logic        ex_mem_wr, mem_wb_flush, halted;
  logic [31:0] stall_count;
  logic [6:0]  vec;

  int errors = 0;
  int checks = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  assign vec = {pc_wr, if_id_wr, if_id_flush, id_ex_wr,
                id_ex_flush, ex_mem_wr, mem_wb_flush};

  hazard_ctrl #(
    .MEM_TIMEOUT(4),
    .TO_W(5),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .ex_mem_rd(ex_mem_rd),
    .ex_rd(ex_rd),
    .ex_redirect(ex_redirect),
    .dmem_req(dmem_req),
    .dmem_ack(dmem_ack),
    .pc_wr(pc_wr),
    .if_id_wr(if_id_wr),
    .if_id_flush(if_id_flush),
    .id_ex_wr(id_ex_wr),
    .id_ex_flush(id_ex_flush),
    .ex_mem_wr(ex_mem_wr),
    .mem_wb_flush(mem_wb_flush),
    .halted(halted),
    .stall_count(stall_count)
  );

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_mem_rd = 1'b0; ex_redirect = 1'b0;
    dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (vec !== V_RST) begin
      errors++;
      $display("FAIL reset_vec got=%b exp=%b", vec, V_RST);
    end
    checks++;
    if (halted !== 1'b0 || stall_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_state halted=%b cnt=%0d exp 0/0",
               halted, stall_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_normal();
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (vec !== V_RUN) begin
        errors++;
        $display("FAIL normal[%0d] got=%b exp=%b", i, vec, V_RUN);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (stall_count !== 32'(exp_stall)) begin
      errors++;
      $display("FAIL normal_cnt got=%0d exp=%0d",
               stall_count, exp_stall);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle_inputs();
    ex_mem_rd = 1'b1; ex_rd = 5'd5;
    id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    #1;
    checks++;
    if (vec !== V_LU) begin
      errors++;
      $display("FAIL lu_rs2 got=%b exp=%b", vec, V_LU);
    end
    exp_stall++;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (vec !== V_RUN || stall_count !== 32'(exp_stall)) begin
      errors++;
      $display("FAIL lu_after vec=%b cnt=%0d exp=%b/%0d",
               vec, stall_count, V_RUN, exp_stall);
    end
    @(negedge clk);
    ex_mem_rd = 1'b1; ex_rd = 5'd0;
    id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (vec !== V_RUN) begin
      errors++;
      $display("FAIL lu_x0 got=%b exp=%b", vec, V_RUN);
    end
    @(negedge clk);
    idle_inputs();
    ex_mem_rd = 1'b1; ex_rd = 5'd9;
    id_rs1 = 5'd9; id_use_rs1 = 1'b0;
    id_rs2 = 5'd9; id_use_rs2 = 1'b0;
    #1;
    checks++;
    if (vec !== V_RUN) begin
      errors++;
      $display("FAIL lu_unused got=%b exp=%b", vec, V_RUN);
    end
    @(negedge clk);
    id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (vec !== V_LU) begin
      errors++;
      $display("FAIL lu_rs1 got=%b exp=%b", vec, V_LU);
    end
    exp_stall++;
    @(negedge clk);
    idle_inputs();
    ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (vec !== V_RUN || stall_count !== 32'(exp_stall)) begin
      errors++;
      $display("FAIL lu_notload vec=%b cnt=%0d exp=%b/%0d",
               vec, stall_count, V_RUN, exp_stall);
    end
  endtask

  task automatic test_redirect();
    @(negedge clk);
    idle_inputs();
    ex_mem_rd = 1'b1; ex_rd = 5'd7;
    id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    ex_redirect = 1'b1;
    #1;
    checks++;
    if (vec !== V_RED) begin
      errors++;
      $display("FAIL redirect got=%b exp=%b", vec, V_RED);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (stall_count !== 32'(exp_stall)) begin
      errors++;
      $display("FAIL redirect_cnt got=%0d exp=%0d",
               stall_count, exp_stall);
    end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      ex_redirect = 1'b1; dmem_req = 1'b1;
      ex_mem_rd = 1'b1; ex_rd = 5'd3;
      id_rs1 = 5'd3; id_use_rs1 = 1'b1;
      #1;
      checks++;
      if (vec !== V_FRZ || halted !== 1'b0) begin
        errors++;
        $display("FAIL freeze[%0d] vec=%b h=%b exp=%b/0",
                 i, vec, halted, V_FRZ);
      end
      exp_stall++;
    end
    @(negedge clk);
    dmem_ack = 1'b1;
    #1;
    checks++;
    if (vec !== V_RED) begin
      errors++;
      $display("FAIL ack_redirect got=%b exp=%b", vec, V_RED);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (vec !== V_RUN || stall_count !== 32'(exp_stall)) begin
      errors++;
      $display("FAIL wait_done vec=%b cnt=%0d exp=%b/%0d",
               vec, stall_count, V_RUN, exp_stall);
    end
    // request withdrawn without ack: back to RUN, counter cleared
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dmem_req = 1'b1;
      exp_stall++;
    end
    @(negedge clk);
    dmem_req = 1'b0;
    #1;
    checks++;
    if (vec !== V_RUN) begin
      errors++;
      $display("FAIL req_drop got=%b exp=%b", vec, V_RUN);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dmem_req = 1'b1;
      #1;
      checks++;
      if (vec !== V_FRZ || halted !== 1'b0) begin
        errors++;
        $display("FAIL rewait[%0d] vec=%b h=%b exp=%b/0",
                 i, vec, halted, V_FRZ);
      end
      exp_stall++;
    end
    @(negedge clk);
    dmem_ack = 1'b1;
    #1;
    checks++;
    if (vec !== V_RUN || halted !== 1'b0) begin
      errors++;
      $display("FAIL rewait_ack vec=%b h=%b exp=%b/0",
               vec, halted, V_RUN);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_inputs();
      dmem_req = 1'b1; dmem_ack = 1'b1;
      ex_mem_rd = i[0]; ex_rd = 5'(i + 10);
      id_rs1 = 5'(i + 1); id_use_rs1 = 1'b1;
      #1;
      checks++;
      if (vec !== V_RUN) begin
        errors++;
        $display("FAIL b2b[%0d] got=%b exp=%b", i, vec, V_RUN);
      end
    end
    @(negedge clk);
    idle_inputs();
    dmem_req = 1'b1;
    #1;
    checks++;
    if (vec !== V_FRZ || stall_count !== 32'(exp_stall)) begin
      errors++;
      $display("FAIL b2b_end vec=%b cnt=%0d exp=%b/%0d",
               vec, stall_count, V_FRZ, exp_stall);
    end
    exp_stall++;
    @(negedge clk);
    dmem_req = 1'b0;
  endtask

  task automatic test_timeout();
    // 4 counted waits allowed; the 5th busy cycle enters HALT
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_inputs();
      dmem_req = 1'b1;
      #1;
      checks++;
      if (vec !== V_FRZ || halted !== 1'b0) begin
        errors++;
        $display("FAIL to_wait[%0d] vec=%b h=%b exp=%b/0",
                 i, vec, halted, V_FRZ);
      end
      exp_stall++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dmem_ack = (i != 0);
      ex_redirect = (i == 2);
      #1;
      checks++;
      if (vec !== V_HLT || halted !== 1'b1) begin
        errors++;
        $display("FAIL halt[%0d] vec=%b h=%b exp=%b/1",
                 i, vec, halted, V_HLT);
      end
      checks++;
      if (stall_count !== 32'(exp_stall)) begin
        errors++;
        $display("FAIL halt_cnt[%0d] got=%0d exp=%0d",
                 i, stall_count, exp_stall);
      end
      exp_stall++;
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (vec !== V_RST || halted !== 1'b0 || stall_count !== 32'd0) begin
      errors++;
      $display("FAIL async_rst vec=%b h=%b cnt=%0d exp=%b/0/0",
               vec, halted, stall_count, V_RST);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    exp_stall = 0;
    #1;
    checks++;
    if (vec !== V_RUN || halted !== 1'b0) begin
      errors++;
      $display("FAIL post_rst vec=%b h=%b exp=%b/0",
               vec, halted, V_RUN);
    end
    @(negedge clk);
    #1;
    checks++;
    if (stall_count !== 32'(exp_stall)) begin
      errors++;
      $display("FAIL post_rst_cnt got=%0d exp=%0d",
               stall_count, exp_stall);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
